vta_sim_wait_sched: RTL and testbench

//  Round-robin scheduler for the simulation wait/stall resource. NUM_REQ requesters
//  (host DPI, memory DPI, ...) each ask for an exclusive wait window. One grant at a time.
//  The core is stalled while a window is open. Exit requests are sequenced: drain, then finish.

---
 rtl/vta_sim_pkg.sv | 14 +
 rtl/vta_rr_arb.sv | 38 +++
 rtl/vta_sim_wait_sched.sv | 144 ++++++++++++++
 tb/tb_vta_sim_wait_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vta_sim_pkg.sv
// Shared types for the simulation wait/stall scheduler.
package vta_sim_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, DONE} sim_sched_st_t;

  typedef logic       dpi1_t;
  typedef logic [7:0] dpi8_t;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int rr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vta_rr_arb.sv
// Combinational round-robin picker: first eligible request at or after rr_ptr_i.
module vta_rr_arb
  import vta_sim_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = rr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PW-1:0]      idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] elig;
  logic               found;
  int                 k;

  assign elig = req_i & mask_i;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (!found && elig[k]) begin
        found     = 1'b1;
        pick_o[k] = 1'b1;
        idx_o     = PW'(k);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vta_sim_wait_sched.sv
// Round-robin wait-window scheduler driving the core stall, with sequenced exit.
//   state | meaning
//   IDLE  | no window open; arbitrate or start exit
//   GRANT | one requester owns the window, core stalled
//   DRAIN | exit pending, core stalled for DRAIN_CYC cycles
//   DONE  | finish asserted, terminal until reset
module vta_sim_wait_sched
  import vta_sim_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_WAIT  = 255,
  parameter int DRAIN_CYC = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               core_stall,
  output logic               timeout,
  input  logic               exit_req,
  output logic               finish,
  output logic [CNT_W-1:0]   win_cnt
);

  localparam int PW = rr_w(NUM_REQ);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [DW-1:0]      drn_cnt_q, drn_cnt_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;
  logic               exit_pend_q, exit_pend_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] arb_pick;
  logic [PW-1:0]      arb_idx;
  logic               arb_valid;
  logic               exit_now;
  logic               rel_free;
  logic               rel_to;

  vta_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (req),
    .mask_i   (~blk_q),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (arb_pick),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  assign exit_now = exit_pend_q | exit_req;
  assign rel_free = ~req[gnt_idx_q];
  assign rel_to   = (win_cnt_q == MAX_W);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    win_cnt_d   = win_cnt_q;
    drn_cnt_d   = drn_cnt_q;
    exit_pend_d = exit_now;
    // A timed-out requester stays blocked until it drops its request.
    blk_d       = blk_q & req;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exit_now) begin
          state_d   = S_DRAIN;
          drn_cnt_d = DW'(DRAIN_CYC - 1);
        end else if (arb_valid) begin
          state_d   = S_GRANT;
          gnt_d     = arb_pick;
          gnt_idx_d = arb_idx;
          win_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (rel_free || rel_to) begin
          gnt_d     = '0;
          win_cnt_d = '0;
          rr_ptr_d  = (gnt_idx_q == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + PW'(1);
          if (!rel_free) begin
            timeout_d        = 1'b1;
            blk_d[gnt_idx_q] = 1'b1;
          end
          if (exit_now) begin
            state_d   = S_DRAIN;
            drn_cnt_d = DW'(DRAIN_CYC - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else if (win_cnt_q != MAX_W) begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_cnt_q == '0) state_d = S_DONE;
        else                 drn_cnt_d = drn_cnt_q - DW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      win_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      blk_q       <= '0;
      exit_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      win_cnt_q   <= win_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      blk_q       <= blk_d;
      exit_pend_q <= exit_pend_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt        = gnt_q;
  assign core_stall = (state_q != S_IDLE);
  assign timeout    = timeout_q;
  assign finish     = (state_q == S_DONE);
  assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_vta_sim_wait_sched.sv
// Directed bench for the wait-window scheduler (MAX_WAIT shortened to 8).
module tb_vta_sim_wait_sched;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       core_stall;
  logic       timeout;
  logic       exit_req;
  logic       finish;
  logic [7:0] win_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  vta_sim_wait_sched #(
    .NUM_REQ   (4),
    .MAX_WAIT  (8),
    .DRAIN_CYC (16),
    .CNT_W     (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .gnt        (gnt),
    .core_stall (core_stall),
    .timeout    (timeout),
    .exit_req   (exit_req),
    .finish     (finish),
    .win_cnt    (win_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    req      = '0;
    exit_req = 1'b0;
    tick();
    tick();
    chk_val("rst_gnt", 32'(gnt), 0);
    chk_val("rst_stall", 32'(core_stall), 0);
    chk_val("rst_timeout", 32'(timeout), 0);
    chk_val("rst_finish", 32'(finish), 0);
    chk_val("rst_wincnt", 32'(win_cnt), 0);
    reset_n = 1'b1;
    tick();
  endtask

  logic [3:0] exp_g;
  logic       saw_gnt;

  initial begin
    do_reset();

    // 1: single requester window
    req = 4'b0010;
    tick();
    chk_val("t1_gnt", 32'(gnt), 32'h2);
    chk_val("t1_stall", 32'(core_stall), 1);
    chk_val("t1_win0", 32'(win_cnt), 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_val("t1_win", 32'(win_cnt), 32'(i));
      chk_val("t1_hold", 32'(gnt), 32'h2);
    end
    req = 4'b0000;
    tick();
    chk_val("t1_rel_gnt", 32'(gnt), 0);
    chk_val("t1_rel_stall", 32'(core_stall), 0);

    // 2: all request, round robin 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      exp_g = 4'b0001 << (w % 4);
      tick();
      chk_val("t2_gnt", 32'(gnt), 32'(exp_g));
      chk_val("t2_onehot", 32'($countones(gnt)), 1);
      tick();
      tick();
      chk_val("t2_win2", 32'(win_cnt), 2);
      req = req & ~exp_g;
      tick();
      chk_val("t2_gap_gnt", 32'(gnt), 0);
      chk_val("t2_gap_stall", 32'(core_stall), 0);
      req = req | exp_g;
    end
    req = 4'b0000;
    tick();

    // 3: stuck requester times out and is blocked; rr_ptr is 1 here
    req = 4'b0100;
    tick();
    chk_val("t3_gnt", 32'(gnt), 32'h4);
    for (int i = 1; i <= 8; i++) tick();
    chk_val("t3_win_max", 32'(win_cnt), 8);
    chk_val("t3_no_to_yet", 32'(timeout), 0);
    tick();
    chk_val("t3_rel_gnt", 32'(gnt), 0);
    chk_val("t3_timeout", 32'(timeout), 1);
    chk_val("t3_rel_stall", 32'(core_stall), 0);
    req = 4'b1100;
    tick();
    chk_val("t3_gnt3", 32'(gnt), 32'h8);
    chk_val("t3_to_pulse", 32'(timeout), 0);
    tick();
    req = 4'b0100;
    tick();
    chk_val("t3_rel3", 32'(gnt), 0);
    tick();
    chk_val("t3_blocked_a", 32'(gnt), 0);
    tick();
    chk_val("t3_blocked_b", 32'(gnt), 0);
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    chk_val("t3_regrant", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    tick();

    // 4: exit mid-window, then drain and done; rr_ptr is 3 here
    req = 4'b0001;
    tick();
    chk_val("t4_gnt", 32'(gnt), 32'h1);
    tick();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    chk_val("t4_not_aborted", 32'(gnt), 32'h1);
    chk_val("t4_win3", 32'(win_cnt), 3);
    req = 4'b0000;
    tick();
    chk_val("t4_drain_gnt", 32'(gnt), 0);
    chk_val("t4_drain_stall", 32'(core_stall), 1);
    chk_val("t4_drain_fin", 32'(finish), 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_val("t4_drain_hold", 32'({core_stall, finish}), 32'b10);
    end
    tick();
    chk_val("t4_finish", 32'(finish), 1);
    chk_val("t4_done_stall", 32'(core_stall), 1);
    req = 4'b1111;
    tick();
    tick();
    chk_val("t4_req_ignored", 32'(gnt), 0);
    chk_val("t4_sticky", 32'(finish), 1);

    // 5: exit and request in the same idle cycle
    do_reset();
    exit_req = 1'b1;
    req      = 4'b0010;
    saw_gnt  = 1'b0;
    tick();
    exit_req = 1'b0;
    chk_val("t5_drain_stall", 32'(core_stall), 1);
    if (gnt != 4'b0000) saw_gnt = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt != 4'b0000) saw_gnt = 1'b1;
    end
    chk_val("t5_never_gnt", 32'(saw_gnt), 0);
    chk_val("t5_finish", 32'(finish), 1);

    // 6: reset during a window
    do_reset();
    req = 4'b0100;
    tick();
    chk_val("t6_gnt", 32'(gnt), 32'h4);
    tick();
    tick();
    chk_val("t6_win2", 32'(win_cnt), 2);
    reset_n = 1'b0;
    tick();
    chk_val("t6_rst_gnt", 32'(gnt), 0);
    chk_val("t6_rst_stall", 32'(core_stall), 0);
    chk_val("t6_rst_win", 32'(win_cnt), 0);
    reset_n = 1'b1;
    req     = 4'b1111;
    tick();
    chk_val("t6_rrptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
